// File: rtl/sd_cmd_pkg.sv
// Shared constants, state encoding and frame payload for the SD CMD framer.
// Also provides the argument selector and the frame builder.
package sd_cmd_pkg;

  localparam int unsigned CMD_FRAME_BITS = 48;
  localparam int unsigned CRC7_W         = 7;
  localparam logic [6:0]  CRC7_POLY      = 7'h09;

  localparam logic [1:0] ARGSEL_DADDR = 2'd0;
  localparam logic [1:0] ARGSEL_RCA   = 2'd1;
  localparam logic [1:0] ARGSEL_ARG   = 2'd2;
  localparam logic [1:0] ARGSEL_ZERO  = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_FRAME,
    ST_POST,
    ST_DONE
  } state_e;

  // CRC field is built as zero; the serialiser drives the live CRC in its place.
  typedef struct packed {
    logic        start;
    logic        tx;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        stop;
  } cmd_frame_t;

  function automatic logic [31:0] select_arg(input logic [1:0]  sel,
                                             input logic [31:0] daddr,
                                             input logic [15:0] rca,
                                             input logic [31:0] arg);
    logic [31:0] res;
    case (sel)
      ARGSEL_DADDR: res = daddr;
      ARGSEL_RCA:   res = {rca, 16'h0000};
      ARGSEL_ARG:   res = arg;
      ARGSEL_ZERO:  res = 32'h0000_0000;
      default:      res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic cmd_frame_t build_frame(input logic [5:0]  idx,
                                             input logic [31:0] arg);
    cmd_frame_t f;
    f.start = START_BIT;
    f.tx    = TX_BIT;
    f.idx   = idx;
    f.arg   = arg;
    f.crc   = 7'h00;
    f.stop  = END_BIT;
    return f;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0). EN folds DIN in; SHIFT drains the register MSB first.
// CLR zeroes the register and may coincide with EN for a same-edge restart.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       EN,
  input  logic       DIN,
  input  logic       SHIFT,
  output logic [6:0] CRC,
  output logic       DOUT
);

  logic [6:0] crc_q, crc_d, base;

  always_comb begin
    base  = CLR ? 7'h00 : crc_q;
    crc_d = base;
    if (EN) begin
      crc_d = {base[5:0], 1'b0} ^ (((DIN ^ base[6]) == 1'b1) ? CRC7_POLY : 7'h00);
    end else if (SHIFT) begin
      crc_d = {base[5:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC  = crc_q;
  assign DOUT = crc_q[6];

endmodule

// File: rtl/sd_cmd_framer.sv
// Builds and serialises a 48-bit SD CMD frame with idle-high padding and internal CRC7.
// Each new bit is decided on the edge it starts, so CMD_OUT comes straight from a flop.
module sd_cmd_framer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned DIV       = 1,
  parameter int unsigned PRE_IDLE  = 8,
  parameter int unsigned POST_IDLE = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [5:0]  CMDIDX,
  input  logic [1:0]  ARGSEL,
  input  logic [31:0] DADDR,
  input  logic [15:0] PUBRCA,
  input  logic [31:0] ARG,
  output logic        BUSY,
  output logic        DONE,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  output logic [6:0]  CRC7_OUT
);

  localparam int unsigned PAD_MAX = (PRE_IDLE > POST_IDLE) ? PRE_IDLE : POST_IDLE;
  localparam int unsigned BIT_MAX = (PAD_MAX > CMD_FRAME_BITS) ? PAD_MAX : CMD_FRAME_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned DIV_W   = $clog2(DIV + 1);

  localparam logic [BIT_W-1:0] PRE_LAST   = BIT_W'((PRE_IDLE == 0) ? 0 : PRE_IDLE - 1);
  localparam logic [BIT_W-1:0] POST_LAST  = BIT_W'((POST_IDLE == 0) ? 0 : POST_IDLE - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(CMD_FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] CRC_TOP    = BIT_W'(CRC7_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);

  state_e                    state_q, state_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [CMD_FRAME_BITS-1:0] sh_q, sh_d, sh_src;
  logic                      cmd_out_q, cmd_out_d;
  logic                      oe_q, oe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [6:0]                crc7_q, crc7_d;

  logic       tick, load_bit;
  logic       crc_clr, crc_en, crc_din, crc_shift, crc_dout;
  logic [6:0] crc_val;

  assign tick = (div_q == '0);

  sd_crc7 u_crc7 (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (crc_clr),
    .EN    (crc_en),
    .DIN   (crc_din),
    .SHIFT (crc_shift),
    .CRC   (crc_val),
    .DOUT  (crc_dout)
  );

  // Phase sequencing; load_bit marks an edge where a new FRAME bit starts.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    div_d     = div_q;
    sh_d      = sh_q;
    sh_src    = sh_q;
    cmd_out_d = cmd_out_q;
    crc7_d    = crc7_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 1'b0;
    crc_shift = 1'b0;
    load_bit  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (START) begin
          sh_src  = build_frame(CMDIDX, select_arg(ARGSEL, DADDR, PUBRCA, ARG));
          sh_d    = sh_src;
          div_d   = DIV_LAST;
          crc_clr = 1'b1;
          if (PRE_IDLE != 0) begin
            state_d = ST_PRE;
            bit_d   = PRE_LAST;
          end else begin
            state_d  = ST_FRAME;
            bit_d    = FRAME_LAST;
            load_bit = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (tick) begin
          div_d = DIV_LAST;
          if (bit_q == '0) begin
            state_d  = ST_FRAME;
            bit_d    = FRAME_LAST;
            load_bit = 1'b1;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      ST_FRAME: begin
        if (tick) begin
          div_d = DIV_LAST;
          if (bit_q == '0) begin
            if (POST_IDLE != 0) begin
              state_d = ST_POST;
              bit_d   = POST_LAST;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            bit_d    = bit_q - BIT_W'(1);
            load_bit = 1'b1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      ST_POST: begin
        if (tick) begin
          div_d = DIV_LAST;
          if (bit_q == '0) begin
            state_d = ST_DONE;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Header/argument bits feed the CRC as they go out; bits 7:1 drain it.
    if (load_bit) begin
      if (bit_d > CRC_TOP) begin
        cmd_out_d = sh_src[CMD_FRAME_BITS-1];
        sh_d      = {sh_src[CMD_FRAME_BITS-2:0], 1'b0};
        crc_en    = 1'b1;
        crc_din   = sh_src[CMD_FRAME_BITS-1];
      end else if (bit_d != '0) begin
        cmd_out_d = crc_dout;
        crc_shift = 1'b1;
        if (bit_d == CRC_TOP) begin
          crc7_d = crc_val;
        end
      end else begin
        cmd_out_d = END_BIT;
      end
    end

    busy_d = (state_d == ST_PRE) || (state_d == ST_FRAME) || (state_d == ST_POST);
    oe_d   = busy_d;
    done_d = (state_d == ST_DONE);
    if (state_d != ST_FRAME) begin
      cmd_out_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      div_q     <= '0;
      sh_q      <= '0;
      cmd_out_q <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc7_q    <= 7'h00;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      sh_q      <= sh_d;
      cmd_out_q <= cmd_out_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc7_q    <= crc7_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CMD_OUT  = cmd_out_q;
  assign CMD_OE   = oe_q;
  assign CRC7_OUT = crc7_q;

endmodule
